// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: generic pipeline-stage register built as a two-entry skid
// buffer. Head register H drives the outputs. Skid register S absorbs one extra
// entry, so in_ready depends only on registered state.
// ctrl is cleared on reset, flush and bubble so that a killed entry reads as a NOP.
// data is only cleared by reset.
// Optional feature macro: PIPE_STAGE_PERF_EN adds saturating stall and
// flush-drop counters. When it is undefined, both counter ports are tied to 0.
//
// state | meaning
// EMPTY | no entry held, out_valid=0
// ONE   | H holds the head entry
// FULL  | H holds the head, S holds the next entry; input blocked
module pipe_skid_stage #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 96,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_drops
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic [CTRL_W-1:0] h_ctrl;
  logic [CTRL_W-1:0] s_ctrl;
  logic [DATA_W-1:0] h_data;
  logic [DATA_W-1:0] s_data;
  logic              push;
  logic              pop;
  logic [1:0]        occ;

  // Encoding of state doubles as the entry count.
  assign occ       = state;
  assign in_ready  = !rst && (state != FULL);
  assign out_valid = !rst && (state != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_ctrl  = out_valid ? h_ctrl : '0;
  assign out_data  = h_data;
  assign occupancy = rst ? 2'd0 : occ;

  // Skid FSM: reset beats flush beats handshake; S is never overtaken by a newer input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      h_ctrl <= '0;
      s_ctrl <= '0;
      h_data <= '0;
      s_data <= '0;
    end else if (flush) begin
      // data kept on purpose: only ctrl has to become a NOP
      state  <= EMPTY;
      h_ctrl <= '0;
      s_ctrl <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            state  <= ONE;
            h_ctrl <= in_ctrl;
            h_data <= in_data;
          end
        end
        ONE: begin
          if (push && pop) begin
            h_ctrl <= in_ctrl;
            h_data <= in_data;
          end else if (push) begin
            state  <= FULL;
            s_ctrl <= in_ctrl;
            s_data <= in_data;
          end else if (pop) begin
            state  <= EMPTY;
            h_ctrl <= '0;
          end
        end
        FULL: begin
          if (pop) begin
            state  <= ONE;
            h_ctrl <= s_ctrl;
            h_data <= s_data;
            s_ctrl <= '0;
          end
        end
        default: begin
          state  <= EMPTY;
          h_ctrl <= '0;
          s_ctrl <= '0;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] drop_q;
  logic [CNT_W+1:0] drop_sum;

  // A killed same-cycle push counts as a dropped entry, in addition to the held ones.
  assign drop_sum = {2'b00, drop_q} + {{CNT_W{1'b0}}, occ}
                  + {{(CNT_W+1){1'b0}}, push};

  // Saturating counters; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      drop_q  <= '0;
    end else begin
      if (out_valid && !out_ready && !flush && (stall_q != CNT_MAX))
        stall_q <= stall_q + CNT_W'(1);
      if (flush)
        drop_q <= (drop_sum > {2'b00, CNT_MAX}) ? CNT_MAX : drop_sum[CNT_W-1:0];
    end
  end

  assign stall_cycles = stall_q;
  assign flush_drops  = drop_q;
`else
  assign stall_cycles = '0;
  assign flush_drops  = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: directed scenarios plus a random phase. A negedge monitor
// compares every output transfer against a queue of accepted inputs, and it
// models the occupancy and the perf counters.
module tb_pipe_skid_stage;
  localparam int CTRL_W = 16;
  localparam int DATA_W = 96;
  localparam int CNT_W  = 4;
  localparam int CMAX   = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cycles;
  logic [CNT_W-1:0]  flush_drops;

  int n_checks = 0;
  int n_errors = 0;

  logic [CTRL_W+DATA_W-1:0] sb_q[$];
  logic [CTRL_W+DATA_W-1:0] sb_head;
  int                       m_occ;
  int                       m_stall = 0;
  int                       m_drop  = 0;
  logic                     m_push;
  logic                     m_pop;
  logic [DATA_W-1:0]        saved_data;

  pipe_skid_stage #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy), .stall_cycles(stall_cycles), .flush_drops(flush_drops)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c);
    in_valid = v;
    in_ctrl  = c;
    in_data  = {$urandom, $urandom, $urandom};
  endtask

  // Scoreboard monitor: it compares the settled outputs, then it advances the model for the coming edge.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      m_stall = 0;
      m_drop  = 0;
    end else begin
      m_occ  = sb_q.size();
      m_push = in_valid && (m_occ != 2);
      m_pop  = (m_occ != 0) && out_ready;
      chk("occupancy", occupancy, m_occ);
      chk("in_ready", in_ready, m_occ != 2);
      chk("out_valid", out_valid, m_occ != 0);
      if (!out_valid) chk("bubble_ctrl", out_ctrl, 0);
`ifdef PIPE_STAGE_PERF_EN
      chk("stall_cycles", stall_cycles, m_stall);
      chk("flush_drops", flush_drops, m_drop);
`else
      chk("stall_cycles", stall_cycles, 0);
      chk("flush_drops", flush_drops, 0);
`endif
      if (m_pop) begin
        sb_head = sb_q.pop_front();
        chk("sb_ctrl", out_ctrl, sb_head[CTRL_W+DATA_W-1:DATA_W]);
        chk("sb_data", out_data, sb_head[DATA_W-1:0]);
      end
      if ((m_occ != 0) && !out_ready && !flush && (m_stall < CMAX)) m_stall++;
      if (flush) begin
        m_drop = m_drop + m_occ + int'(m_push);
        if (m_drop > CMAX) m_drop = CMAX;
        sb_q.delete();
      end else if (m_push) begin
        sb_q.push_back({in_ctrl, in_data});
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b1, 16'hABCD);
    // reset with in_valid high
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_occupancy", occupancy, 0);
    rst = 1'b0;
    drive(1'b0, 16'h0);
    tick();

    // streaming with 1-cycle latency
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, CTRL_W'(i));
      tick();
      chk("stream_ctrl", out_ctrl, i);
      chk("stream_in_ready", in_ready, 1);
      chk("stream_occ", occupancy, 1);
    end
    drive(1'b0, 16'h0);
    tick(); tick();

    // back-pressure
    out_ready = 1'b0;
    drive(1'b1, 16'h0011); tick();
    drive(1'b1, 16'h0022); tick();
    chk("bp_occ", occupancy, 2);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_ctrl", out_ctrl, 16'h0011);
    drive(1'b1, 16'h0033);
    tick(); tick();
    chk("bp_ctrl_stable", out_ctrl, 16'h0011);
    out_ready = 1'b1;
    tick();
    chk("bp_ctrl_b", out_ctrl, 16'h0022);
    tick();
    chk("bp_ctrl_c", out_ctrl, 16'h0033);
    drive(1'b0, 16'h0);
    tick();
    chk("bp_drained", out_valid, 0);

    // flush when FULL
    out_ready = 1'b0;
    drive(1'b1, 16'h0044); saved_data = in_data; tick();
    drive(1'b1, 16'h0055); tick();
    drive(1'b1, 16'h0066);
    flush = 1'b1; tick();
    flush = 1'b0; drive(1'b0, 16'h0);
    chk("fl_full_valid", out_valid, 0);
    chk("fl_full_ctrl", out_ctrl, 0);
    chk("fl_full_data", out_data, saved_data);
    chk("fl_full_in_ready", in_ready, 1);
`ifdef PIPE_STAGE_PERF_EN
    chk("fl_full_drops", flush_drops, 2);
`endif
    tick();

    // flush in ONE with a same-cycle push
    drive(1'b1, 16'h0077); tick();
    drive(1'b1, 16'h0033);
    flush = 1'b1; tick();
    flush = 1'b0; drive(1'b0, 16'h0);
    out_ready = 1'b1;
    chk("fl_one_occ", occupancy, 0);
`ifdef PIPE_STAGE_PERF_EN
    chk("fl_one_drops", flush_drops, 4);
`endif
    tick(); tick();
    chk("fl_one_no_33", out_valid, 0);

    // stall counter saturation
    rst = 1'b1; tick(); rst = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 16'h0099); tick();
    drive(1'b0, 16'h0);
    for (int i = 0; i < 5; i++) tick();
`ifdef PIPE_STAGE_PERF_EN
    chk("stall_5", stall_cycles, 5);
`endif
    for (int i = 0; i < 15; i++) tick();
`ifdef PIPE_STAGE_PERF_EN
    chk("stall_sat", stall_cycles, 15);
`else
    chk("stall_off", stall_cycles, 0);
`endif
    chk("stall_ctrl_hold", out_ctrl, 16'h0099);

    // reset mid-transfer
    drive(1'b1, 16'h00AA); tick();
    rst = 1'b1; tick();
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_data", out_data, 0);
    chk("rst_mid_occ", occupancy, 0);
    chk("rst_mid_in_ready", in_ready, 0);
    rst = 1'b0; drive(1'b0, 16'h0);
    tick();

    // random traffic with occasional flush
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), CTRL_W'($urandom));
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush     = 1'($urandom_range(0, 24) == 0);
      tick();
    end
    flush = 1'b0; out_ready = 1'b1; drive(1'b0, 16'h0);
    tick(); tick(); tick();
    chk("final_empty", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
